// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : RV32I instruction decode stage. Register-file addressing,
//               immediate generation, writeback bypass, load-use hazard
//               detection and the ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    input  logic        flush,
    output logic [4:0]  addr_rs1,
    output logic [4:0]  addr_rs2,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [31:0] out_rs1_val,
    output logic [31:0] out_rs2_val,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic        out_is_load
);

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_IALU   = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic        w_rs1_used;
    logic        w_rs2_used;
    logic        w_writes_rd;
    logic        w_is_load;
    logic [31:0] w_imm;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic        w_hazard;

    assign w_opcode = in_inst[6:0];
    assign w_rd     = in_inst[11:7];
    assign addr_rs1 = in_inst[19:15];
    assign addr_rs2 = in_inst[24:20];

    // Source-usage, writeback and load classification from the opcode
    always_comb begin
        w_rs1_used  = 1'b1;
        w_rs2_used  = 1'b0;
        w_writes_rd = 1'b0;
        w_is_load   = 1'b0;
        case (w_opcode)
            c_OP_R: begin
                w_rs2_used  = 1'b1;
                w_writes_rd = 1'b1;
            end
            c_OP_IALU, c_OP_JALR: w_writes_rd = 1'b1;
            c_OP_LOAD: begin
                w_writes_rd = 1'b1;
                w_is_load   = 1'b1;
            end
            c_OP_STORE, c_OP_BRANCH: w_rs2_used = 1'b1;
            c_OP_LUI, c_OP_AUIPC, c_OP_JAL: begin
                w_rs1_used  = 1'b0;
                w_writes_rd = 1'b1;
            end
            default: ;
        endcase
    end

    // Immediate generation by instruction format; unknown formats yield zero
    always_comb begin
        w_imm = 32'd0;
        case (w_opcode)
            c_OP_IALU, c_OP_LOAD, c_OP_JALR:
                w_imm = {{20{in_inst[31]}}, in_inst[31:20]};
            c_OP_STORE:
                w_imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            c_OP_BRANCH:
                w_imm = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                         in_inst[30:25], in_inst[11:8], 1'b0};
            c_OP_LUI, c_OP_AUIPC:
                w_imm = {in_inst[31:12], 12'd0};
            c_OP_JAL:
                w_imm = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                         in_inst[20], in_inst[30:21], 1'b0};
            default: w_imm = 32'd0;
        endcase
    end

    // Writeback bypass: the register file is read in the same cycle it is
    // written, so a matching writeback must override the stale read data.
    assign w_rs1_val = (wb_en && (wb_rd != 5'd0) && (wb_rd == addr_rs1)) ? wb_data : rs1_data;
    assign w_rs2_val = (wb_en && (wb_rd != 5'd0) && (wb_rd == addr_rs2)) ? wb_data : rs2_data;

    // Load-use hazard: the load in ID/EX produces a source this instruction needs
    assign w_hazard = in_valid && out_valid && out_is_load && (out_rd != 5'd0) &&
                      ((w_rs1_used && (out_rd == addr_rs1)) ||
                       (w_rs2_used && (out_rd == addr_rs2)));

    // A flush kills the slot anyway, so holding IF would only lose a cycle
    assign stall = w_hazard && !flush;

    // ID/EX pipeline register; flush or hazard inserts a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_pc        <= 32'd0;
            out_inst      <= 32'd0;
            out_rs1_val   <= 32'd0;
            out_rs2_val   <= 32'd0;
            out_imm       <= 32'd0;
            out_rd        <= 5'd0;
            out_reg_write <= 1'b0;
            out_is_load   <= 1'b0;
        end else begin
            out_pc      <= in_pc;
            out_inst    <= in_inst;
            out_rs1_val <= w_rs1_val;
            out_rs2_val <= w_rs2_val;
            out_imm     <= w_imm;
            out_rd      <= w_rd;
            if (flush || w_hazard) begin
                out_valid     <= 1'b0;
                out_reg_write <= 1'b0;
                out_is_load   <= 1'b0;
            end else begin
                out_valid     <= in_valid;
                out_reg_write <= in_valid && w_writes_rd && (w_rd != 5'd0);
                out_is_load   <= in_valid && w_is_load;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage. A behavioural model
//               predicts the ID/EX slot and stall each cycle; directed
//               vectors add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        flush;
    logic [4:0]  addr_rs1;
    logic [4:0]  addr_rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [31:0] out_rs1_val;
    logic [31:0] out_rs2_val;
    logic [31:0] out_imm;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_is_load;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf [32];

    decode_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_pc(in_pc),
        .in_inst(in_inst), .flush(flush), .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .stall(stall), .out_valid(out_valid), .out_pc(out_pc),
        .out_inst(out_inst), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_imm(out_imm), .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_is_load(out_is_load)
    );

    always #5 clk = ~clk;

    // Register file model feeding the read ports
    assign rs1_data = rf[addr_rs1];
    assign rs2_data = rf[addr_rs2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        rs1u;
        logic        rs2u;
        logic        wr;
        logic        ld;
        logic [31:0] imm;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] i);
        dec_t d;
        d = '0;
        d.rs1u = !(i[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
        d.rs2u = i[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
        d.wr   = i[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                                7'b0010111, 7'b1101111, 7'b1100111};
        d.ld   = (i[6:0] == 7'b0000011);
        if (i[6:0] inside {7'b0010011, 7'b0000011, 7'b1100111})
            d.imm = 32'($signed(i[31:20]));
        else if (i[6:0] == 7'b0100011)
            d.imm = 32'($signed({i[31:25], i[11:7]}));
        else if (i[6:0] == 7'b1100011)
            d.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
        else if (i[6:0] inside {7'b0110111, 7'b0010111})
            d.imm = {i[31:12], 12'd0};
        else if (i[6:0] == 7'b1101111)
            d.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
        return d;
    endfunction

    logic        m_valid, m_wr, m_ld;
    logic [31:0] m_pc, m_inst, m_rs1, m_rs2, m_imm;
    logic [4:0]  m_rd;

    function automatic logic model_stall();
        dec_t d;
        logic [4:0] s1, s2;
        d  = decode(in_inst);
        s1 = in_inst[19:15];
        s2 = in_inst[24:20];
        return !flush && in_valid && m_valid && m_ld && m_rd != 0 &&
               ((d.rs1u && m_rd == s1) || (d.rs2u && m_rd == s2));
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] a);
        if (wb_en && wb_rd != 0 && wb_rd == a) return wb_data;
        return rf[a];
    endfunction

    // Model of the ID/EX slot: what the slot must hold after each edge
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 0; m_wr <= 0; m_ld <= 0; m_pc <= 0; m_inst <= 0;
            m_rs1 <= 0; m_rs2 <= 0; m_imm <= 0; m_rd <= 0;
        end else begin
            logic take;
            dec_t d;
            d    = decode(in_inst);
            take = in_valid && !flush && !model_stall();
            m_valid <= take;
            m_wr    <= take && d.wr && in_inst[11:7] != 0;
            m_ld    <= take && d.ld;
            m_pc    <= in_pc;
            m_inst  <= in_inst;
            m_rs1   <= operand(in_inst[19:15]);
            m_rs2   <= operand(in_inst[24:20]);
            m_imm   <= d.imm;
            m_rd    <= in_inst[11:7];
        end
    end

    // Compare DUT against the model every cycle, away from the rising edge
    always @(negedge clk) begin
        chk("addr_rs1", 32'(addr_rs1), 32'(in_inst[19:15]));
        chk("addr_rs2", 32'(addr_rs2), 32'(in_inst[24:20]));
        chk("stall", 32'(stall), 32'(model_stall()));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_reg_write", 32'(out_reg_write), 32'(m_wr));
        chk("out_is_load", 32'(out_is_load), 32'(m_ld));
        if (m_valid) begin
            chk("out_pc", out_pc, m_pc);
            chk("out_inst", out_inst, m_inst);
            chk("out_rs1_val", out_rs1_val, m_rs1);
            chk("out_rs2_val", out_rs2_val, m_rs2);
            chk("out_imm", out_imm, m_imm);
            chk("out_rd", 32'(out_rd), 32'(m_rd));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic fl);
        in_valid = v; in_pc = pc; in_inst = inst; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_pc"}, out_pc, 0);
        chk({tag, "_inst"}, out_inst, 0);
        chk({tag, "_rs1"}, out_rs1_val, 0);
        chk({tag, "_rs2"}, out_rs2_val, 0);
        chk({tag, "_imm"}, out_imm, 0);
        chk({tag, "_rd"}, 32'(out_rd), 0);
        chk({tag, "_rw"}, 32'(out_reg_write), 0);
        chk({tag, "_ld"}, 32'(out_is_load), 0);
        chk({tag, "_stall"}, 32'(stall), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rf[0] = 0;
        rf[3] = 32'h11;
        reset = 1; wb_en = 0; wb_rd = 0; wb_data = 0;
        drive(0, 0, 0, 0);
        tick();
        chk_all_zero("rst");
        tick();
        reset = 0;

        // addi x5,x0,-1
        drive(1, 32'h100, 32'hFFF00293, 0);
        tick();
        chk("addi_imm", out_imm, 32'hFFFFFFFF);
        chk("addi_rd", 32'(out_rd), 5);
        chk("addi_rw", 32'(out_reg_write), 1);
        chk("addi_valid", 32'(out_valid), 1);

        // bypass rs1 from writeback: addi x8,x3,1
        wb_en = 1; wb_rd = 3; wb_data = 32'h22;
        drive(1, 32'h104, 32'h00118413, 0);
        tick();
        chk("byp_rs1", out_rs1_val, 32'h22);
        // writeback to x0 must not bypass: addi x8,x0,1
        wb_rd = 0;
        drive(1, 32'h108, 32'h00100413, 0);
        tick();
        chk("byp_x0", out_rs1_val, 32'h0);
        // rs2 bypass: add x9,x3,x4
        wb_rd = 4; wb_data = 32'h44;
        drive(1, 32'h10C, 32'h004184B3, 0);
        tick();
        chk("byp_rs2", out_rs2_val, 32'h44);
        chk("byp_rs2_rs1", out_rs1_val, 32'h11);
        wb_en = 0;

        // lw x6,0(x1) ; add x7,x6,x2 -> one stall, bubble, then add
        drive(1, 32'h110, 32'h0000A303, 0);
        tick();
        chk("lw_ld", 32'(out_is_load), 1);
        drive(1, 32'h114, 32'h002303B3, 0);
        #1 chk("lu_stall", 32'(stall), 1);
        tick();
        chk("lu_bubble", 32'(out_valid), 0);
        chk("lu_stall_gone", 32'(stall), 0);
        tick();
        chk("lu_issue", 32'(out_valid), 1);
        chk("lu_issue_inst", out_inst, 32'h002303B3);

        // lw x6 ; lui x6,0x12345 -> no stall
        drive(1, 32'h118, 32'h0000A303, 0);
        tick();
        drive(1, 32'h11C, 32'h12345337, 0);
        #1 chk("lui_nostall", 32'(stall), 0);
        tick();
        chk("lui_valid", 32'(out_valid), 1);
        chk("lui_imm", out_imm, 32'h12345000);

        // lw x6 ; add x7,x6,x2 with flush -> no stall, bubble
        drive(1, 32'h120, 32'h0000A303, 0);
        tick();
        drive(1, 32'h124, 32'h002303B3, 1);
        #1 chk("fl_stall", 32'(stall), 0);
        tick();
        chk("fl_bubble", 32'(out_valid), 0);

        // lw x6 ; sw x6,0(x1) -> hazard through rs2
        drive(1, 32'h128, 32'h0000A303, 0);
        tick();
        drive(1, 32'h12C, 32'h0060A023, 0);
        #1 chk("sw_stall", 32'(stall), 1);
        tick();
        tick();
        chk("sw_rw", 32'(out_reg_write), 0);
        // sw x2,8(x1), beq x1,x2,-4, jal x1,-8, invalid slot
        drive(1, 32'h130, 32'h0020A423, 0);
        tick();
        chk("sw_imm", out_imm, 32'h8);
        drive(1, 32'h134, 32'hFE208EE3, 0);
        tick();
        chk("beq_imm", out_imm, 32'hFFFFFFFC);
        drive(1, 32'h138, 32'hFF9FF0EF, 0);
        tick();
        chk("jal_imm", out_imm, 32'hFFFFFFF8);
        drive(0, 32'h13C, 32'h0000A303, 0);
        tick();
        chk("inv_ld", 32'(out_is_load), 0);
        // lw x0 ; add x7,x0,x0 -> no stall on x0
        drive(1, 32'h140, 32'h0000A003, 0);
        tick();
        drive(1, 32'h144, 32'h000003B3, 0);
        #1 chk("x0_nostall", 32'(stall), 0);
        tick();

        // async reset mid-stall
        drive(1, 32'h148, 32'h0000A303, 0);
        tick();
        drive(1, 32'h14C, 32'h002303B3, 0);
        #1 chk("mid_stall", 32'(stall), 1);
        #1 reset = 1;
        #1 chk_all_zero("arst");
        tick();
        reset = 0;
        drive(1, 32'h200, 32'hFFF00293, 0);
        tick();
        chk("post_rst_valid", 32'(out_valid), 1);
        chk("post_rst_pc", out_pc, 32'h200);
        drive(0, 0, 0, 0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have no parameters; all widths are fixed (RV32I, XLEN=32).
REQ-002 SHALL expose ports, one per line:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  IF/ID slot holds a valid instruction
- in_pc  in  32  PC of in_inst
- in_inst  in  32  instruction word
- flush  in  1  taken branch/jump resolved in EX; kill the decode slot
- addr_rs1  out  5  register-file read address, = in_inst[19:15]
- addr_rs2  out  5  register-file read address, = in_inst[24:20]
- rs1_data  in  32  register-file read data for addr_rs1, same cycle
- rs2_data  in  32  register-file read data for addr_rs2, same cycle
- wb_en  in  1  writeback write enable, also driven to the register file
- wb_rd  in  5  writeback destination register
- wb_data  in  32  writeback data
- stall  out  1  hold IF and the IF/ID slot this cycle (load-use hazard)
- out_valid  out  1  ID/EX slot valid
- out_pc, out_inst  out  32 each  registered copies of in_pc and in_inst
- out_rs1_val, out_rs2_val  out  32 each  operand values after bypass
- out_imm  out  32  sign-extended immediate
- out_rd  out  5  destination, = in_inst[11:7]
- out_reg_write  out  1  instruction writes rd (rd != 0)
- out_is_load  out  1  opcode 0000011

Function
REQ-003 SHALL drive addr_rs1 and addr_rs2 combinationally from in_inst, with no register stage.
REQ-004 SHALL decode rs1 as used for every opcode except LUI (0110111), AUIPC (0010111), and JAL (1101111).
REQ-005 SHALL decode rs2 as used only for opcodes 0110011 (R), 0100011 (S), and 1100011 (B).
REQ-006 SHALL generate out_imm by format:
- I (0010011, 0000011, 1100111): inst[31:20], sign-extended
- S: {inst[31:25], inst[11:7]}, sign-extended
- B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended
- U: {inst[31:12], 12'b0}
- J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}, sign-extended
- all other opcodes: 0
REQ-007 SHALL apply a writeback bypass: if wb_en=1, wb_rd!=0, and wb_rd==addr_rs1, then out_rs1_val takes wb_data, not rs1_data; addr_rs2 is handled identically.
REQ-008 SHALL assert stall combinationally when all of the following hold:
- in_valid=1
- out_valid=1 and out_is_load=1 and out_rd!=0
- out_rd equals a used source (rs1 per REQ-004, rs2 per REQ-005)
REQ-009 SHALL, on a stall cycle without flush, load a bubble into ID/EX: out_valid=0, out_reg_write=0, out_is_load=0. The IF/ID contents are held upstream, so the instruction re-decodes next cycle. Stall lasts exactly one cycle per load-use pair.
REQ-010 SHALL, on flush=1, load a bubble into ID/EX regardless of in_valid or hazard, and force stall=0; flush has priority over stall.
REQ-011 SHALL, otherwise, capture all decode results into ID/EX on each rising edge with out_valid=in_valid; when in_valid=0, out_reg_write and out_is_load SHALL be 0.
REQ-012 SHALL set out_reg_write=1 only for opcodes that write rd, and only when rd!=0. Those opcodes are R, I-ALU, load, LUI, AUIPC, JAL, and JALR. Store and branch opcodes SHALL give out_reg_write=0.
REQ-013 SHALL give each accepted instruction a latency of one cycle from IF/ID to ID/EX.
REQ-014 SHALL not assert stall while out_valid=0.

Reset
REQ-015 SHALL, while reset=1, asynchronously clear every ID/EX register (out_valid, out_pc, out_inst, out_rs1_val, out_rs2_val, out_imm, out_rd, out_reg_write, out_is_load) to 0; stall SHALL therefore read 0.
REQ-016 SHALL, if reset asserts mid-stall or mid-flush, discard the in-flight slot; the first edge after reset deassertion accepts in_inst normally.

Verification
REQ-017 SHALL be verified with at least the following directed scenarios:
- `addi x5,x0,-1` (0xFFF00293), in_valid=1 -> next cycle: out_imm=0xFFFFFFFF, out_rd=5, out_reg_write=1, out_valid=1.
- rs1=x3, rs1_data=0x11, with wb_en=1, wb_rd=3, wb_data=0x22 -> out_rs1_val=0x22. Repeat with wb_rd=0 targeting x0 -> out_rs1_val=rs1_data.
- `lw x6,0(x1)` followed by `add x7,x6,x2` -> stall=1 for one cycle, then a bubble (out_valid=0), then the add issues with out_valid=1.
- `lw x6` followed by `lui x6` (no source use) -> stall=0, no bubble.
- flush=1 during a load-use stall -> stall=0, and next cycle out_valid=0.
- reset asserted asynchronously between edges -> all outputs 0 immediately; first post-reset instruction issues with 1-cycle latency.
